// File: rtl/seg7_pair_decoder.sv
`timescale 1ns/1ps
// seg7_pair_decoder: debounces a two-digit active-low seven-segment bus and decodes it back to 0..15.
// Latency: STABLE_CYCLES+3 edges from the first sample of a held pattern to out_valid or err.
// Backpressure: out_value/out_valid held while out_ready=0; a newer decode overwrites and sets sticky overrun.
module seg7_pair_decoder #(
  // Consecutive equal samples required before a decode; legal range 1..255.
  parameter int STABLE_CYCLES = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [13:0] seg_in,
  input  logic        out_ready,
  output logic [3:0]  out_value,
  output logic        out_valid,
  output logic        err,
  output logic        overrun
);

  // Saturation point of the stability counter.
  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  // Both digits dark: the encoder's idle pattern, also the reset value of acc_pat.
  localparam logic [13:0] PAT_BLANK = 14'h3FFF;

  // Tens-digit codes the encoder can emit.
  localparam logic [6:0] TENS_BLANK = 7'h7F;
  localparam logic [6:0] TENS_ONE   = 7'h79;

  typedef enum logic {
    S_TRACK  = 1'b0,
    S_DECODE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CLS_BLANK   = 2'd0,
    CLS_LEGAL   = 2'd1,
    CLS_ILLEGAL = 2'd2
  } cls_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] val;
  } digit_t;

  // Reverse lookup of one active-low units digit (bit 0 = a .. bit 6 = g).
  function automatic digit_t units_lut(input logic [6:0] code);
    digit_t d;
    d.legal = 1'b1;
    d.val   = 4'd0;
    case (code)
      7'h40:   d.val = 4'd0;
      7'h79:   d.val = 4'd1;
      7'h24:   d.val = 4'd2;
      7'h30:   d.val = 4'd3;
      7'h19:   d.val = 4'd4;
      7'h12:   d.val = 4'd5;
      7'h02:   d.val = 4'd6;
      7'h78:   d.val = 4'd7;
      7'h00:   d.val = 4'd8;
      7'h10:   d.val = 4'd9;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // Synchronizer, stability counter and pattern bookkeeping.
  logic [13:0] s1_q, s1_d;
  logic [13:0] s2_q, s2_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [13:0] acc_pat_q, acc_pat_d;
  logic [13:0] cand_q, cand_d;
  state_t      state_q, state_d;

  // Output registers.
  logic [3:0]  out_value_q, out_value_d;
  logic        out_valid_q, out_valid_d;
  logic        err_q, err_d;
  logic        overrun_q, overrun_d;

  // Classification of the candidate pattern.
  cls_t        cls;
  logic [3:0]  dec_val;
  digit_t      units_dig;
  logic [6:0]  tens_code;
  logic        xfer;

  // Two-flop synchronizer: seg_in is asynchronous to CLOCK_50.
  always_comb begin
    s1_d = seg_in;
    s2_d = s1_q;
  end

  // Stability counter: restarts on any sample change, saturates at the window length.
  always_comb begin
    cnt_d = cnt_q;
    if (s1_q != s2_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q != STABLE_CNT) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Classify the captured candidate: blank, legal 0..15, or illegal.
  always_comb begin
    tens_code = cand_q[13:7];
    units_dig = units_lut(cand_q[6:0]);
    cls       = CLS_ILLEGAL;
    dec_val   = 4'd0;
    if (cand_q == PAT_BLANK) begin
      cls = CLS_BLANK;
    end else if (tens_code == TENS_BLANK && units_dig.legal) begin
      cls     = CLS_LEGAL;
      dec_val = units_dig.val;
    end else if (tens_code == TENS_ONE && units_dig.legal && units_dig.val <= 4'd5) begin
      cls     = CLS_LEGAL;
      dec_val = units_dig.val + 4'd10;
    end
  end

  // FSM next state plus acceptance and output-register updates.
  // The candidate is captured from s2 on the edge that enters S_DECODE, i.e. the
  // very sample that completed the stability window; s2 may already hold a newer
  // sample during S_DECODE, and that sample must not leak into this decode.
  always_comb begin
    state_d     = state_q;
    acc_pat_d   = acc_pat_q;
    cand_d      = cand_q;
    xfer        = out_valid_q & out_ready;
    out_value_d = out_value_q;
    out_valid_d = out_valid_q & ~xfer;
    err_d       = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      S_TRACK: begin
        if (cnt_q == STABLE_CNT && s2_q != acc_pat_q) begin
          cand_d  = s2_q;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        acc_pat_d = cand_q;
        state_d   = S_TRACK;
        case (cls)
          CLS_LEGAL: begin
            out_value_d = dec_val;
            out_valid_d = 1'b1;
            // Overwriting a value the consumer has not taken on this edge.
            if (out_valid_q && !out_ready) begin
              overrun_d = 1'b1;
            end
          end
          CLS_ILLEGAL: begin
            err_d = 1'b1;
          end
          default: begin
          end
        endcase
      end
      default: begin
        state_d = S_TRACK;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q        <= PAT_BLANK;
      s2_q        <= PAT_BLANK;
      cnt_q       <= 8'd0;
      acc_pat_q   <= PAT_BLANK;
      cand_q      <= PAT_BLANK;
      state_q     <= S_TRACK;
      out_value_q <= 4'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      cnt_q       <= cnt_d;
      acc_pat_q   <= acc_pat_d;
      cand_q      <= cand_d;
      state_q     <= state_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_value = out_value_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_pair_decoder.sv
`timescale 1ns/1ps
// tb_seg7_pair_decoder: directed vectors; expected transfers/err pulses queued at stimulus time.
// A negedge monitor pops the queue on every transfer or err pulse; level checks cover holds and flags.
// Inputs change 2ns after a rising edge; outputs are sampled at the falling edge.
module tb_seg7_pair_decoder;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic [13:0] seg_in   = 14'h3FFF;
  logic        out_ready = 1'b0;
  logic [3:0]  out_value;
  logic        out_valid;
  logic        err;
  logic        overrun;

  typedef struct packed {
    logic       is_err;
    logic [3:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Hand-encoded legal patterns for values 0..15: {tens, units}, active-low.
  logic [13:0] code_tbl [16] = '{
    14'h3FC0, 14'h3FF9, 14'h3FA4, 14'h3FB0, 14'h3F99, 14'h3F92, 14'h3F82, 14'h3FF8,
    14'h3F80, 14'h3F90, 14'h3CC0, 14'h3CF9, 14'h3CA4, 14'h3CB0, 14'h3C99, 14'h3C92
  };

  always #5 CLOCK_50 = ~CLOCK_50;

  seg7_pair_decoder #(.STABLE_CYCLES(4)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .seg_in    (seg_in),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_valid (out_valid),
    .err       (err),
    .overrun   (overrun)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Advance n rising edges, landing 2ns after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #2;
    end
  endtask

  task automatic push_val(input logic [3:0] v);
    exp_t e;
    e.is_err = 1'b0;
    e.val    = v;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.val    = 4'd0;
    exp_q.push_back(e);
  endtask

  // Monitor: every transfer and every err-high cycle must match the next queued event.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (RESET_N) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer: got value %0d, expected no transfer", out_value);
        end else begin
          e = exp_q.pop_front();
          check("transfer_is_err_event", {15'd0, e.is_err}, 16'd0);
          check("transfer_value", {12'd0, out_value}, {12'd0, e.val});
        end
      end
      if (err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err: got err=1, expected err=0");
        end else begin
          e = exp_q.pop_front();
          check("err_event_kind", {15'd0, e.is_err}, 16'd1);
        end
      end
    end
  end

  initial begin
    // Reset state.
    step(3);
    check("reset_out_valid", {15'd0, out_valid}, 16'd0);
    check("reset_out_value", {12'd0, out_value}, 16'd0);
    check("reset_err", {15'd0, err}, 16'd0);
    check("reset_overrun", {15'd0, overrun}, 16'd0);

    // Value 0 held with out_ready=0: latency to edge 7, then held.
    seg_in  = 14'h3FC0;
    RESET_N = 1'b1;
    step(7);
    check("lat_valid_before_edge7", {15'd0, out_valid}, 16'd0);
    step(1);
    check("lat_valid_after_edge7", {15'd0, out_valid}, 16'd1);
    check("lat_value_after_edge7", {12'd0, out_value}, 16'd0);
    for (int i = 0; i < 50; i++) begin
      step(1);
      check("hold_valid", {15'd0, out_valid}, 16'd1);
      check("hold_value", {12'd0, out_value}, 16'd0);
    end
    push_val(4'd0);
    out_ready = 1'b1;
    step(2);
    check("after_xfer_valid", {15'd0, out_valid}, 16'd0);

    // Blank clears acc_pat without output, then sweep 0..15.
    seg_in = 14'h3FFF;
    step(10);
    for (int v = 0; v < 16; v++) begin
      seg_in = code_tbl[v];
      push_val(4'(v));
      step(10);
    end
    check("sweep_overrun", {15'd0, overrun}, 16'd0);
    check("sweep_queue_drained", 16'(exp_q.size()), 16'd0);

    // Decode 5, short glitch to 8, return to 5: nothing further.
    seg_in = 14'h3F92;
    push_val(4'd5);
    step(10);
    seg_in = 14'h3F80;
    step(3);
    seg_in = 14'h3F92;
    step(20);
    check("glitch_valid", {15'd0, out_valid}, 16'd0);
    check("glitch_queue_drained", 16'(exp_q.size()), 16'd0);

    // Illegal "00": one-cycle err, outputs untouched.
    seg_in = 14'h2040;
    push_err();
    step(8);
    check("illegal00_err_high", {15'd0, err}, 16'd1);
    check("illegal00_valid", {15'd0, out_valid}, 16'd0);
    step(1);
    check("illegal00_err_one_cycle", {15'd0, err}, 16'd0);
    step(2);
    // Illegal "16": tens "1" with units 6.
    seg_in = 14'h3C82;
    push_err();
    step(10);
    seg_in = 14'h3FFF;
    step(10);
    check("illegal_overrun", {15'd0, overrun}, 16'd0);

    // Decode coinciding with a transfer: no overrun, valid stays high.
    out_ready = 1'b0;
    seg_in    = 14'h3FF9;
    push_val(4'd1);
    step(10);
    check("coin_first_valid", {15'd0, out_valid}, 16'd1);
    check("coin_first_value", {12'd0, out_value}, 16'd1);
    seg_in = 14'h3FA4;
    push_val(4'd2);
    step(7);
    out_ready = 1'b1;
    step(1);
    check("coin_valid_kept", {15'd0, out_valid}, 16'd1);
    check("coin_new_value", {12'd0, out_value}, 16'd2);
    check("coin_no_overrun", {15'd0, overrun}, 16'd0);
    step(1);
    check("coin_valid_fall", {15'd0, out_valid}, 16'd0);
    step(2);

    // Overrun: 3 then 9 with out_ready=0.
    out_ready = 1'b0;
    seg_in    = 14'h3FB0;
    step(10);
    seg_in = 14'h3F90;
    step(10);
    push_val(4'd9);
    check("ovr_value", {12'd0, out_value}, 16'd9);
    check("ovr_valid", {15'd0, out_valid}, 16'd1);
    check("ovr_flag", {15'd0, overrun}, 16'd1);
    out_ready = 1'b1;
    step(2);
    check("ovr_valid_fall", {15'd0, out_valid}, 16'd0);
    check("ovr_sticky", {15'd0, overrun}, 16'd1);

    // Reset mid-operation while 7 is held and valid.
    out_ready = 1'b0;
    seg_in    = 14'h3FF8;
    step(10);
    check("pre_rst_valid", {15'd0, out_valid}, 16'd1);
    check("pre_rst_value", {12'd0, out_value}, 16'd7);
    RESET_N = 1'b0;
    #1;
    check("rst_async_valid", {15'd0, out_valid}, 16'd0);
    check("rst_async_value", {12'd0, out_value}, 16'd0);
    check("rst_async_overrun", {15'd0, overrun}, 16'd0);
    step(2);
    RESET_N = 1'b1;
    step(7);
    check("rst_redecode_before_edge7", {15'd0, out_valid}, 16'd0);
    step(1);
    check("rst_redecode_valid", {15'd0, out_valid}, 16'd1);
    check("rst_redecode_value", {12'd0, out_value}, 16'd7);
    push_val(4'd7);
    out_ready = 1'b1;
    step(3);

    check("final_queue_drained", 16'(exp_q.size()), 16'd0);
    check("final_overrun", {15'd0, overrun}, 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
